// File: rtl/mem_stage_pkg.sv
// Shared pipeline control struct plus the memory-stage state encoding.
package mem_stage_pkg;

  typedef struct packed {
    logic       regWrite;
    logic       memToReg;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic       aluSrc;
    logic [1:0] aluOp;
  } ControlSignals;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam ControlSignals BUBBLE = '0;

  function automatic logic is_mem_op(input ControlSignals c);
    return c.memRead | c.memWrite;
  endfunction

endpackage

// File: rtl/mem_stage_timeout_counter.sv
// Counts ack-less REQ cycles; expired flags the TIMEOUT-th cycle. Saturates, never wraps.
module mem_timeout_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CW'(TIMEOUT))) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: pass-through for ALU ops, stalled req/ack access for loads/stores.
// Handshake: dmem_req is held with stable we/addr/wdata until a one-cycle dmem_ack (or timeout).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int         TIMEOUT  = 15,
  parameter logic [7:0] ERR_DATA = 8'hFF
) (
  input  logic          clk,
  input  logic          reset,
  input  ControlSignals control_in,
  input  logic [7:0]    alu_result_in,
  input  logic [7:0]    store_data_in,
  input  logic [2:0]    rd_in,
  output logic          stall_out,
  output ControlSignals control_out,
  output logic [7:0]    mem_data_out,
  output logic [7:0]    alu_result_out,
  output logic [2:0]    rd_out,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [7:0]    dmem_addr,
  output logic [7:0]    dmem_wdata,
  input  logic [7:0]    dmem_rdata,
  input  logic          dmem_ack,
  output logic          mem_err,
  output mem_state_t    state
);

  mem_state_t    state_next;
  ControlSignals hold_ctrl;
  logic [7:0]    hold_addr;
  logic [7:0]    hold_wdata;
  logic [2:0]    hold_rd;
  logic          hold_we;
  logic [7:0]    data_reg;
  logic [7:0]    data_next;
  logic          latch;
  logic          cnt_clear;
  logic          cnt_en;
  logic          expired;
  logic          err_set;

  mem_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold_ctrl  <= BUBBLE;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_rd    <= '0;
      hold_we    <= 1'b0;
      data_reg   <= '0;
      mem_err    <= 1'b0;
    end else begin
      state    <= state_next;
      data_reg <= data_next;
      mem_err  <= mem_err | err_set;
      if (latch) begin
        hold_ctrl  <= control_in;
        hold_addr  <= alu_result_in;
        hold_wdata <= store_data_in;
        hold_rd    <= rd_in;
        hold_we    <= control_in.memWrite;
      end
    end
  end

  always_comb begin
    state_next     = state;
    data_next      = data_reg;
    stall_out      = 1'b0;
    control_out    = BUBBLE;
    alu_result_out = '0;
    rd_out         = '0;
    mem_data_out   = '0;
    dmem_req       = 1'b0;
    latch          = 1'b0;
    cnt_clear      = 1'b0;
    cnt_en         = 1'b0;
    err_set        = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem_op(control_in)) begin
          latch      = 1'b1;
          cnt_clear  = 1'b1;
          stall_out  = 1'b1;
          state_next = REQ;
        end else begin
          control_out    = control_in;
          alu_result_out = alu_result_in;
          rd_out         = rd_in;
        end
      end
      REQ: begin
        dmem_req  = 1'b1;
        stall_out = 1'b1;
        if (dmem_ack) begin
          data_next  = hold_we ? 8'h00 : dmem_rdata;
          state_next = DONE;
        end else if (expired) begin
          err_set    = 1'b1;
          data_next  = hold_we ? 8'h00 : ERR_DATA;
          state_next = DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        // EX/MEM still shows the same instruction here; it must not be re-accepted.
        control_out    = hold_ctrl;
        alu_result_out = hold_addr;
        rd_out         = hold_rd;
        mem_data_out   = data_reg;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory-side fields are gated by dmem_req so they read zero outside REQ and during reset.
  assign dmem_we    = dmem_req & hold_we;
  assign dmem_addr  = dmem_req ? hold_addr  : 8'h00;
  assign dmem_wdata = dmem_req ? hold_wdata : 8'h00;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through vector table plus hand-written memory sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic          clk;
  logic          reset;
  ControlSignals control_in;
  logic [7:0]    alu_result_in;
  logic [7:0]    store_data_in;
  logic [2:0]    rd_in;
  logic          stall_out;
  ControlSignals control_out;
  logic [7:0]    mem_data_out;
  logic [7:0]    alu_result_out;
  logic [2:0]    rd_out;
  logic          dmem_req;
  logic          dmem_we;
  logic [7:0]    dmem_addr;
  logic [7:0]    dmem_wdata;
  logic [7:0]    dmem_rdata;
  logic          dmem_ack;
  logic          mem_err;
  mem_state_t    state;

  int n_cmp = 0;
  int n_mis = 0;

  mem_stage #(.TIMEOUT(15), .ERR_DATA(8'hFF)) dut (
    .clk            (clk),
    .reset          (reset),
    .control_in     (control_in),
    .alu_result_in  (alu_result_in),
    .store_data_in  (store_data_in),
    .rd_in          (rd_in),
    .stall_out      (stall_out),
    .control_out    (control_out),
    .mem_data_out   (mem_data_out),
    .alu_result_out (alu_result_out),
    .rd_out         (rd_out),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dmem_ack       (dmem_ack),
    .mem_err        (mem_err),
    .state          (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // control encodings: {regWrite, memToReg, memRead, memWrite, branch, aluSrc, aluOp[1:0]}
  localparam logic [7:0] C_ALU   = 8'b1000_0010;
  localparam logic [7:0] C_ALUI  = 8'b1000_0101;
  localparam logic [7:0] C_BR    = 8'b0000_1001;
  localparam logic [7:0] C_LOAD  = 8'b1110_0100;
  localparam logic [7:0] C_STORE = 8'b0001_0100;
  localparam logic [7:0] C_BOTH  = 8'b0011_0100;

  typedef struct {
    logic [7:0] ctrl;
    logic [7:0] alu;
    logic [2:0] rd;
    logic       ack;
    logic [7:0] exp_ctrl;
    logic [7:0] exp_alu;
    logic [2:0] exp_rd;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] c, input logic [7:0] a, input logic [7:0] wd,
                       input logic [2:0] r, input logic ack, input logic [7:0] rdata);
    control_in    = ControlSignals'(c);
    alu_result_in = a;
    store_data_in = wd;
    rd_in         = r;
    dmem_ack      = ack;
    dmem_rdata    = rdata;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_ctrl"},  control_out, 8'h00);
    chk({tag, "_rd"},    {5'd0, rd_out}, 8'h00);
    chk({tag, "_alu"},   alu_result_out, 8'h00);
    chk({tag, "_stall"}, {7'd0, stall_out}, 8'h01);
  endtask

  // Issues a load or store, acks it on REQ cycle ack_at (0 = never); returns REQ cycle count.
  task automatic mem_op(input string tag, input logic [7:0] c, input logic [7:0] a,
                        input logic [7:0] wd, input logic [2:0] r, input int ack_at,
                        input logic [7:0] rdata, input logic exp_we, output int n_req);
    n_req = 0;
    drive(c, a, wd, r, 1'b0, 8'h00);
    settle;
    chk_bubble({tag, "_acc"});
    chk({tag, "_acc_req"}, {7'd0, dmem_req}, 8'h00);
    tick;
    for (int i = 1; i <= 40; i++) begin
      dmem_ack   = (i == ack_at);
      dmem_rdata = (i == ack_at) ? rdata : 8'h5A;
      settle;
      if (!dmem_req) break;
      n_req++;
      if (i == 1 || i == ack_at) begin
        chk_bubble({tag, "_req"});
        chk({tag, "_we"},    {7'd0, dmem_we}, {7'd0, exp_we});
        chk({tag, "_addr"},  dmem_addr, a);
        chk({tag, "_wdata"}, dmem_wdata, exp_we ? wd : 8'h00);
      end else if (dmem_addr !== a || dmem_we !== exp_we) begin
        chk({tag, "_addr_stable"}, dmem_addr, a);
      end
      tick;
    end
    dmem_ack = 1'b0;
  endtask

  int n_req;

  initial begin
    reset = 1'b1;
    drive(8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00);
    #2;
    chk("rst_state",  {6'd0, state}, {6'd0, IDLE});
    chk("rst_err",    {7'd0, mem_err}, 8'h00);
    chk("rst_req",    {7'd0, dmem_req}, 8'h00);
    chk("rst_addr",   dmem_addr, 8'h00);
    chk("rst_ctrl",   control_out, 8'h00);
    chk("rst_stall",  {7'd0, stall_out}, 8'h00);
    @(posedge clk);
    #1 reset = 1'b0;

    // pass-through table, including spurious acks in IDLE
    vecs[0] = '{C_ALU,  8'h3C, 3'd5, 1'b0, C_ALU,  8'h3C, 3'd5, 1'b0};
    vecs[1] = '{C_ALUI, 8'h81, 3'd7, 1'b0, C_ALUI, 8'h81, 3'd7, 1'b0};
    vecs[2] = '{C_BR,   8'h00, 3'd0, 1'b1, C_BR,   8'h00, 3'd0, 1'b0};
    vecs[3] = '{8'h00,  8'hFF, 3'd1, 1'b1, 8'h00,  8'hFF, 3'd1, 1'b0};
    vecs[4] = '{C_ALU,  8'h55, 3'd2, 1'b1, C_ALU,  8'h55, 3'd2, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].ctrl, vecs[i].alu, 8'hEE, vecs[i].rd, vecs[i].ack, 8'h99);
      settle;
      chk($sformatf("pt%0d_ctrl", i),  control_out, vecs[i].exp_ctrl);
      chk($sformatf("pt%0d_alu", i),   alu_result_out, vecs[i].exp_alu);
      chk($sformatf("pt%0d_rd", i),    {5'd0, rd_out}, {5'd0, vecs[i].exp_rd});
      chk($sformatf("pt%0d_stall", i), {7'd0, stall_out}, {7'd0, vecs[i].exp_stall});
      chk($sformatf("pt%0d_req", i),   {7'd0, dmem_req}, 8'h00);
      chk($sformatf("pt%0d_mdata", i), mem_data_out, 8'h00);
      tick;
      chk($sformatf("pt%0d_state", i), {6'd0, state}, {6'd0, IDLE});
    end
    dmem_ack = 1'b0;

    // load acked on first REQ cycle
    mem_op("ld", C_LOAD, 8'h10, 8'h00, 3'd3, 1, 8'hA5, 1'b0, n_req);
    chk("ld_nreq",  n_req[7:0], 8'd1);
    chk("ld_ctrl",  control_out, C_LOAD);
    chk("ld_data",  mem_data_out, 8'hA5);
    chk("ld_rd",    {5'd0, rd_out}, 8'd3);
    chk("ld_alu",   alu_result_out, 8'h10);
    chk("ld_stall", {7'd0, stall_out}, 8'h00);
    tick;
    chk("ld_idle",  {6'd0, state}, {6'd0, IDLE});

    // store acked after 4 wait cycles
    mem_op("st", C_STORE, 8'h20, 8'h77, 3'd4, 5, 8'hC3, 1'b1, n_req);
    chk("st_nreq",  n_req[7:0], 8'd5);
    chk("st_ctrl",  control_out, C_STORE);
    chk("st_data",  mem_data_out, 8'h00);
    chk("st_alu",   alu_result_out, 8'h20);
    tick;

    // memRead and memWrite both set behaves as a store
    mem_op("both", C_BOTH, 8'h30, 8'h12, 3'd1, 2, 8'h44, 1'b1, n_req);
    chk("both_data", mem_data_out, 8'h00);
    tick;

    // ack arriving in the 15th REQ cycle is a success
    mem_op("late", C_LOAD, 8'h40, 8'h00, 3'd6, 15, 8'h3C, 1'b0, n_req);
    chk("late_nreq", n_req[7:0], 8'd15);
    chk("late_data", mem_data_out, 8'h3C);
    chk("late_err",  {7'd0, mem_err}, 8'h00);
    tick;

    // reset during REQ cycle 3
    drive(C_LOAD, 8'h50, 8'h00, 3'd2, 1'b0, 8'h00);
    tick;
    tick;
    tick;
    settle;
    chk("rr_req_before", {7'd0, dmem_req}, 8'h01);
    #1 reset = 1'b1;
    #1;
    chk("rr_req",   {7'd0, dmem_req}, 8'h00);
    chk("rr_state", {6'd0, state}, {6'd0, IDLE});
    chk("rr_err",   {7'd0, mem_err}, 8'h00);
    drive(C_ALU, 8'h00, 8'h00, 3'd0, 1'b0, 8'h00);
    @(posedge clk);
    #1 reset = 1'b0;
    mem_op("ld2", C_LOAD, 8'h60, 8'h00, 3'd5, 2, 8'h6B, 1'b0, n_req);
    chk("ld2_data", mem_data_out, 8'h6B);
    chk("ld2_rd",   {5'd0, rd_out}, 8'd5);
    tick;

    // load never acked: times out after 15 REQ cycles
    mem_op("to", C_LOAD, 8'h70, 8'h00, 3'd7, 0, 8'h00, 1'b0, n_req);
    chk("to_nreq",  n_req[7:0], 8'd15);
    chk("to_data",  mem_data_out, 8'hFF);
    chk("to_err",   {7'd0, mem_err}, 8'h01);
    chk("to_stall", {7'd0, stall_out}, 8'h00);
    tick;
    drive(C_ALU, 8'h3C, 8'h00, 3'd5, 1'b0, 8'h00);
    settle;
    chk("to_err_sticky", {7'd0, mem_err}, 8'h01);
    chk("to_pt_alu",     alu_result_out, 8'h3C);
    tick;
    tick;
    chk("to_err_sticky2", {7'd0, mem_err}, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 8-bit pipeline. Sits between the EX/MEM register and MEM_WB.
- Issues data-memory loads/stores over a variable-latency req/ack interface, inserting bubbles and stalling upstream until the access completes.
- Non-memory instructions pass through with zero added latency.
- Produces control, load data, ALU result and destination register for MEM_WB.

Parameters:
- TIMEOUT, 15, max cycles in REQ without dmem_ack before abort (range 1..255).
- ERR_DATA, 8'hFF, value driven on mem_data_out for an aborted load.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- control_in  in  ControlSignals  control from EX/MEM; uses fields memRead, memWrite
- alu_result_in  in  8  ALU result / memory address
- store_data_in  in  8  store data
- rd_in  in  3  destination register
- stall_out  out  1  hold EX/MEM and earlier stages this cycle
- control_out  out  ControlSignals  to MEM_WB (all-zero = bubble)
- mem_data_out  out  8  load data to MEM_WB
- alu_result_out  out  8  ALU result to MEM_WB
- rd_out  out  3  destination register to MEM_WB
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = store
- dmem_addr  out  8  address
- dmem_wdata  out  8  store data
- dmem_rdata  in  8  load data, valid when dmem_ack=1
- dmem_ack  in  1  one-cycle completion pulse
- mem_err  out  1  sticky timeout flag

Behaviour:
- FSM states: IDLE, REQ, DONE. Reset to IDLE.
- Reset values: mem_err=0, all hold registers 0, dmem_* outputs 0. Outputs are the IDLE combinational values for a zero input.
- is_mem = control_in.memRead | control_in.memWrite. If both are set, the access is a store.
- IDLE, !is_mem:
  - Pass-through: control_out=control_in, alu_result_out=alu_result_in, rd_out=rd_in, mem_data_out=0, stall_out=0.
- IDLE, is_mem:
  - Latch control, address, wdata, rd and we into hold registers.
  - Outputs a bubble: control_out='0, rd_out=0, alu_result_out=0, mem_data_out=0.
  - stall_out=1. Next state REQ. Timeout counter cleared.
- REQ:
  - dmem_req=1; dmem_we/addr/wdata come from hold registers and stay stable the whole state. Bubble outputs; stall_out=1.
  - dmem_ack=1: capture dmem_rdata (load) or 0 (store) into the data register. Next state DONE.
  - No ack: counter increments. Timeout is ack-less with counter==TIMEOUT-1, i.e. the TIMEOUT-th REQ cycle. On timeout: set mem_err, data register=ERR_DATA for a load or 0 for a store, next state DONE.
  - Ack in the timeout cycle counts as success; mem_err is not set.
- DONE:
  - Present the held instruction: control_out=held control, rd_out=held rd, alu_result_out=held addr, mem_data_out=data register. stall_out=0; dmem_req=0.
  - EX/MEM still holds the same instruction this cycle; it is ignored, not re-issued. Next state IDLE.
- Minimum memory-op latency: 3 cycles (accept, REQ with ack, DONE). Each extra wait cycle adds 1.
- dmem_ack outside REQ is ignored.
- mem_err clears only on reset.
- Reset asserted mid-operation: immediate return to IDLE, dmem_req drops asynchronously, the pending access is dropped.
- Counter width is clog2(TIMEOUT+1). The counter saturates and never wraps.

Decomposition:
- Package Defs:
  - ControlSignals (already shared).
  - Add mem_state_t enum {IDLE, REQ, DONE}.
  - Add constant BUBBLE = '0 of ControlSignals.
- One sub-module: mem_timeout_counter (clear, enable, parameter TIMEOUT, output expired). The FSM and data path stay in mem_stage.

Test Plan:
- ALU op, control_in.memRead=0/memWrite=0, alu_result_in=8'h3C, rd_in=5 -> same cycle control_out=control_in, alu_result_out=8'h3C, rd_out=5, stall_out=0, dmem_req=0.
- Load, addr 8'h10, ack on first REQ cycle with rdata=8'hA5 -> stall 1,1; DONE cycle mem_data_out=8'hA5, rd_out=rd_in, stall_out=0; 3 cycles total.
- Store, addr 8'h20, wdata 8'h77, ack after 4 wait cycles -> dmem_req high 5 cycles with we=1, addr=8'h20, wdata=8'h77 stable; DONE mem_data_out=0; bubbles before DONE.
- Load with no ack, TIMEOUT=15 -> dmem_req high exactly 15 cycles, then DONE with mem_data_out=8'hFF, mem_err=1 held thereafter.
- Reset pulsed during REQ cycle 3 -> dmem_req=0 immediately, state IDLE, mem_err=0; a later load completes normally.
- Spurious dmem_ack in IDLE with an ALU op -> no state change, pass-through unaffected.
